// File: rtl/button_pio_irq.sv
// rtl/button_pio_irq.sv - interrupt-capable debounced input PIO (sync, debounce, edge capture, masked IRQ)
// Optional debouncer: define BUTTON_PIO_DEBOUNCE_EN; otherwise the debounced state is the synchroniser output.
module button_pio_irq #(
  parameter int               WIDTH           = 4,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               EDGE_TYPE       = 0,
  parameter logic [WIDTH-1:0] INIT_VALUE      = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]                  w_sync;
  logic [WIDTH-1:0]                  w_deb;
  logic [WIDTH-1:0]                  r_deb_d;
  logic [WIDTH-1:0]                  w_edge;
  logic [WIDTH-1:0]                  r_cap;
  logic [WIDTH-1:0]                  r_mask;
  logic [WIDTH-1:0]                  w_clr;
  logic [WIDTH-1:0]                  w_rd_mux;
  logic                              w_wr;
  logic                              w_unused_wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= {SYNC_STAGES{INIT_VALUE}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], in_port};
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef BUTTON_PIO_DEBOUNCE_EN
  localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0]    r_cnt [WIDTH];
  logic [WIDTH-1:0] r_deb;

  // Any disagreement that does not persist restarts the count from zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_deb <= INIT_VALUE;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (w_sync[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_deb[i] <= w_sync[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_deb = r_deb;
`else
  assign w_deb = w_sync;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_deb_d <= INIT_VALUE;
    end else begin
      r_deb_d <= w_deb;
    end
  end

  always_comb begin
    w_edge = w_deb ^ r_deb_d;
    if (EDGE_TYPE == 0) begin
      w_edge = w_deb & ~r_deb_d;
    end else if (EDGE_TYPE == 1) begin
      w_edge = ~w_deb & r_deb_d;
    end
  end

  assign w_wr  = chipselect & ~write_n;
  assign w_clr = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  // A new edge in the same cycle as its clear keeps the bit set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cap  <= '0;
      r_mask <= '0;
    end else begin
      r_cap <= (r_cap & ~w_clr) | w_edge;
      if (w_wr && address == 2'd2) r_mask <= writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    w_rd_mux = w_deb;
    case (address)
      2'd1:    w_rd_mux = w_sync;
      2'd2:    w_rd_mux = r_mask;
      2'd3:    w_rd_mux = r_cap;
      default: w_rd_mux = w_deb;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= 32'(w_rd_mux);
    end
  end

  assign irq            = |(r_cap & r_mask);
  assign w_unused_wdata = &{1'b0, writedata};

endmodule

// File: tb/tb_button_pio_irq.sv
// tb/tb_button_pio_irq.sv - directed self-checking bench for button_pio_irq
// Latency expectations follow BUTTON_PIO_DEBOUNCE_EN (debounce of 4 clocks when defined).
module tb_button_pio_irq;

`ifdef BUTTON_PIO_DEBOUNCE_EN
  localparam int DB     = 4;
  localparam bit DEB_EN = 1'b1;
`else
  localparam int DB     = 0;
  localparam bit DEB_EN = 1'b0;
`endif
  localparam int LAT = 1 + DB;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in0, in2;
  logic [31:0] readdata0, readdata2;
  logic        irq0, irq2;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  button_pio_irq #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0), .INIT_VALUE(4'b0000))
  u_dut0 (.clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
          .writedata(writedata), .in_port(in0), .readdata(readdata0), .irq(irq0));

  button_pio_irq #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2), .INIT_VALUE(4'b0000))
  u_dut2 (.clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
          .writedata(writedata), .in_port(in2), .readdata(readdata2), .irq(irq2));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in0        = '0;
    in2        = '0;
    step();
    step();
    chk("reset_readdata", readdata0, 32'h0);
    chk("reset_irq", {31'b0, irq0}, 32'h0);
    reset_n = 1'b1;

    // Reset readback of all four registers
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      step();
      chk("rd_reset0", readdata0, 32'h0);
      chk("rd_reset2", readdata2, 32'h0);
    end
    wr(2'd0, 32'hFFFF_FFFF);
    address = 2'd0;
    step();
    chk("data_read_only", readdata0, 32'h0);
    wr(2'd2, 32'hFFFF_FFF0);
    address = 2'd2;
    step();
    chk("mask_upper_ignored", readdata0, 32'h0);

    // Debounced rising edge
    wr(2'd2, 32'h1);
    address = 2'd2;
    step();
    chk("mask_readback", readdata0, 32'h1);
    address = 2'd0;
    in0     = 4'b0001;
    for (int k = 1; k <= LAT + 2; k++) begin
      step();
      chk("rise_data", readdata0, (k == LAT + 2) ? 32'h1 : 32'h0);
      chk("rise_irq", {31'b0, irq0}, (k == LAT + 2) ? 32'h1 : 32'h0);
    end
    address = 2'd3;
    step();
    chk("rise_cap", readdata0, 32'h1);
    address = 2'd1;
    step();
    chk("raw_read", readdata0, 32'h1);
    chk("idle_irq2", {31'b0, irq2}, 32'h0);

    // Bounce rejection
    in0 = 4'b0000;
    repeat (LAT + 2) step();
    wr(2'd3, 32'h1);
    chk("cleared_irq", {31'b0, irq0}, 32'h0);
    for (int i = 0; i < 10; i++) begin
      in0[0] = ~in0[0];
      repeat (3) step();
    end
    repeat (LAT + 2) step();
    address = 2'd0;
    step();
    chk("bounce_data", readdata0, 32'h0);
    address = 2'd3;
    step();
    chk("bounce_cap", readdata0, DEB_EN ? 32'h0 : 32'h1);
    chk("bounce_irq", {31'b0, irq0}, DEB_EN ? 32'h0 : 32'h1);
    wr(2'd3, 32'h1);

    // Write-1-to-clear and set/clear collision
    address = 2'd3;
    in0     = 4'b0011;
    repeat (LAT + 3) step();
    chk("cap_0011", readdata0, 32'h3);
    wr(2'd3, 32'h1);
    step();
    chk("w1c_bit0", readdata0, 32'h2);
    in0[1] = 1'b0;
    repeat (LAT + 2) step();
    in0[1] = 1'b1;
    repeat (LAT + 1) step();
    wr(2'd3, 32'h2);
    step();
    chk("w1c_collision", readdata0, 32'h2);
    wr(2'd3, 32'h2);
    step();
    chk("w1c_plain", readdata0, 32'h0);
    chk("w1c_irq", {31'b0, irq0}, 32'h0);

    // Masking with any-edge detection
    wr(2'd2, 32'h0);
    in2 = 4'b0100;
    repeat (8) step();
    in2 = 4'b0000;
    repeat (8) step();
    address = 2'd3;
    step();
    chk("any_cap", readdata2, 32'h4);
    chk("masked_irq", {31'b0, irq2}, 32'h0);
    chk("other_cap", readdata0, 32'h0);
    wr(2'd2, 32'h4);
    chk("mask_irq", {31'b0, irq2}, 32'h1);
    chk("mask_irq0", {31'b0, irq0}, 32'h0);
    in2 = 4'b0100;
    repeat (8) step();
    wr(2'd3, 32'h4);
    step();
    chk("any_cleared", readdata2, 32'h0);
    in2 = 4'b0000;
    repeat (LAT + 3) step();
    chk("any_fall", readdata2, 32'h4);

    // Reset in the middle of a debounce
    in0[3] = 1'b1;
    repeat (4) step();
    reset_n = 1'b0;
    #1;
    chk("async_rst_rd", readdata0, 32'h0);
    chk("async_rst_irq0", {31'b0, irq0}, 32'h0);
    chk("async_rst_irq2", {31'b0, irq2}, 32'h0);
    in0 = 4'b0000;
    in2 = 4'b0000;
    repeat (2) step();
    reset_n = 1'b1;
    repeat (10) step();
    address = 2'd3;
    step();
    chk("post_rst_cap", readdata0, 32'h0);
    address = 2'd0;
    step();
    chk("post_rst_data", readdata0, 32'h0);
    address = 2'd2;
    step();
    chk("post_rst_mask", readdata2, 32'h0);
    chk("post_rst_irq", {31'b0, irq0}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/button_pio_irq.md
Name: button_pio_irq

Overview:
Parametrised, interrupt-capable input PIO for push-buttons and switches on the embedded CPU's Avalon-MM bus. Per-bit input path: synchroniser, then debouncer, then programmable edge detector. Detected edges set sticky edge-capture bits; each bit can be masked into a single level IRQ to the CPU. The bus keeps the 4-word register window and registered 1-cycle read of the existing simple input PIO.

Parameters:
WIDTH, 4, number of input bits (1..32)
SYNC_STAGES, 2, synchroniser flops per bit (>=2)
DEBOUNCE_CYCLES, 50000, consecutive stable clocks required before debounced state changes (>=1)
EDGE_TYPE, 0, edge that sets capture: 0 rising, 1 falling, 2 any
INIT_VALUE, 0, WIDTH-bit reset value of sync chain and debounced state (set to all-ones for active-low buttons)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  2  register word select
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
in_port  in  WIDTH  raw asynchronous pin inputs
readdata  out  32  registered read data
irq  out  1  level interrupt to CPU

Behaviour:
- Clock is clk. Reset is reset_n: asynchronous, active-low.
- Reset values: readdata=0; irq=0; IRQMASK=0; EDGECAPTURE=0; all debounce counters=0; sync chain, debounced state and delayed debounced state=INIT_VALUE. Reset release therefore never produces an edge. Reset asserted mid-debounce or mid-edge discards all progress.
- Register map (bits above WIDTH-1 read 0, writes to them ignored):
  - 0 DATA: debounced state, read-only.
  - 1 RAW: synchroniser output, read-only.
  - 2 IRQMASK: R/W.
  - 3 EDGECAPTURE: read; write-1-to-clear.
- A write takes effect on the clk edge where chipselect=1 and write_n=0. Writes to 0 and 1 are ignored.
- Read: every clk, readdata <= zero-extended mux(address). This gives 1-cycle latency, independent of chipselect, with no read strobe required.
- Synchroniser: SYNC_STAGES flop chain per bit. A pin change first sampled at edge N appears at the sync output at edge N+SYNC_STAGES-1.
- Debouncer, per bit, counter width $clog2(DEBOUNCE_CYCLES+1):
  - sync == deb: cnt <= 0.
  - sync != deb and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - sync != deb and cnt == DEBOUNCE_CYCLES-1: deb <= sync, cnt <= 0.
  - Net effect: deb changes exactly DEBOUNCE_CYCLES clocks after the sync output changes, if sync stays stable. Any bounce back restarts the count.
  - The counter never wraps.
- Edge detect: deb_d <= deb each clk. Edge terms:
  - rise = deb & ~deb_d
  - fall = ~deb & deb_d
  - any = deb ^ deb_d
  - The term selected by EDGE_TYPE sets the EDGECAPTURE bit on the next clk edge.
- EDGECAPTURE update: cap <= (cap & ~clr) | edge, where clr = writedata[WIDTH-1:0] on a valid write to address 3. If a set and a clear hit the same bit in the same cycle, the set wins. Capture bits are sticky and saturate; repeated edges are not counted.
- irq = |(EDGECAPTURE & IRQMASK), driven combinationally from flops (glitch-free). irq rises in the same cycle the capture bit becomes visible.
- An IRQMASK write changes irq in the following cycle. Masked bits still capture edges.

Optional Feature:
- Macro: BUTTON_PIO_DEBOUNCE_EN.
- Defined: debouncer present, exactly as described above.
- Undefined:
  - Counters are removed and deb = sync output directly, so the change occurs DEBOUNCE_CYCLES cycles earlier.
  - DEBOUNCE_CYCLES is ignored.
  - Register map, edge and IRQ behaviour are unchanged.

Test Plan:
1. Reset and readback: reset_n low, then high; read addresses 0..3 with INIT_VALUE=4'b0000 -> readdata=0 each, one cycle after address is applied; irq=0.
2. Debounced rising edge (WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=0):
   - in_port 0->4'b0001, held; IRQMASK=1.
   - DATA reads 1 only after sync plus 4 clocks.
   - EDGECAPTURE=1 and irq=1 one cycle later.
3. Bounce rejection: in_port bit0 toggles every 3 clocks for 30 clocks with DEBOUNCE_CYCLES=4 -> DATA stays 0, EDGECAPTURE stays 0, irq stays 0.
4. Write-1-to-clear collision:
   - With EDGECAPTURE=4'b0011, write 4'b0001 -> reads 4'b0010.
   - A write of 4'b0010 coinciding with a new bit1 edge -> bit1 stays 1.
5. Masking and EDGE_TYPE=2:
   - Bit2 pulse 0->1->0 (each held >4 clocks) with IRQMASK=0 -> EDGECAPTURE=4'b0100, irq=0.
   - Write IRQMASK=4'b0100 -> irq=1 next cycle.
6. Reset mid-debounce: assert reset_n with cnt=2 on bit3 -> all state returns to reset values immediately; after release, no edge is captured.
